// File: rtl/hc_csr_bank.sv
// hc_csr_bank -- MMIO CSR bank for HardCloud AFUs.
//
// Decodes CCI-P MMIO reads/writes and serves DFH, AFU ID, scratch, DSM base,
// control, status, run-cycle counter and NUM_BUFFERS buffer address/size pairs.
// A small IDLE/RUN/DONE state machine is driven by CONTROL writes and the
// accelerator completion/error pulses.
//
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   rx_mmio          MMIO request channel (read/write valid, header, data)
//   tx_mmio          MMIO read response, one cycle after each read request
//   hc_dsm_base      DSM cache-line address (byte address >> 6)
//   hc_control       last CONTROL write, bits [31:0]
//   hc_start/abort   one-cycle pulses on accepted start / abort
//   hc_busy          high while running
//   buf_addr/size    packed per-buffer cache-line addresses and sizes
//   accel_done/error accelerator completion / error pulses

// Subset of the CCI-P MMIO channel types used by this block.
package ccip_if_pkg;
    typedef struct packed {
        logic [15:0] address;   // 32-bit word index
        logic [1:0]  length;    // 2'b01 = 8 bytes
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;
endpackage

module hc_csr_bank
    import ccip_if_pkg::*;
#(
    parameter int         NUM_BUFFERS = 2,
    parameter logic [127:0] AFU_ID    = 128'hC000C966_0D82_4272_9AEF_FE5F84570612,
    parameter int         SIZE_W      = 32,
    parameter int         CYCLE_W     = 48
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  t_if_ccip_c0_Rx                rx_mmio,
    output t_if_ccip_c2_Tx                tx_mmio,
    output logic [41:0]                   hc_dsm_base,
    output logic [31:0]                   hc_control,
    output logic                          hc_start,
    output logic                          hc_abort,
    output logic                          hc_busy,
    output logic [NUM_BUFFERS*42-1:0]     buf_addr,
    output logic [NUM_BUFFERS*SIZE_W-1:0] buf_size,
    input  logic                          accel_done,
    input  logic                          accel_error
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

    // Word indices (byte offset >> 2)
    localparam logic [15:0] A_DFH     = 16'h0000;
    localparam logic [15:0] A_AFU_L   = 16'h0002;
    localparam logic [15:0] A_AFU_H   = 16'h0004;
    localparam logic [15:0] A_SCRATCH = 16'h000A;
    localparam logic [15:0] A_DSM     = 16'h000C;
    localparam logic [15:0] A_CTRL    = 16'h000E;
    localparam logic [15:0] A_STATUS  = 16'h0010;
    localparam logic [15:0] A_CYCLES  = 16'h0012;
    localparam logic [63:0] DFH_VAL   = 64'h1000_0100_0000_0000;

    function automatic logic [15:0] buf_addr_idx(input int i);
        return 16'(32'h40 + 4 * i);
    endfunction

    function automatic logic [15:0] buf_size_idx(input int i);
        return 16'(32'h42 + 4 * i);
    endfunction

    state_e                                 state_q;
    logic [63:0]                            scratch_q, dsm_q;
    logic [31:0]                            control_q;
    logic                                   done_q, err_q, rej_q;
    logic [CYCLE_W-1:0]                     cycles_q;
    logic [NUM_BUFFERS-1:0][63:0]           baddr_q;
    logic [NUM_BUFFERS-1:0][SIZE_W-1:0]     bsize_q;
    logic                                   start_q, abort_q;
    t_if_ccip_c2_Tx                         tx_q;

    logic [15:0] addr;
    logic        wr_en, start_req, abort_req;
    logic [63:0] rd_data_d, status;

    assign addr   = rx_mmio.hdr.address;
    // Only full 8-byte writes have any effect.
    assign wr_en  = rx_mmio.mmioWrValid && (rx_mmio.hdr.length == 2'b01);
    // Abort takes priority when both control bits are set.
    assign abort_req = wr_en && (addr == A_CTRL) && rx_mmio.data[1];
    assign start_req = wr_en && (addr == A_CTRL) && rx_mmio.data[0] && !rx_mmio.data[1];

    assign status = {58'd0, state_q, rej_q, err_q, done_q, state_q == ST_RUN};

    // Read mux works on current register values, so a same-cycle write is
    // not visible to the read.
    always_comb begin
        rd_data_d = '0;
        case (addr)
            A_DFH:     rd_data_d = DFH_VAL;
            A_AFU_L:   rd_data_d = AFU_ID[127:64];
            A_AFU_H:   rd_data_d = AFU_ID[63:0];
            A_SCRATCH: rd_data_d = scratch_q;
            A_DSM:     rd_data_d = dsm_q;
            A_CTRL:    rd_data_d = 64'(control_q);
            A_STATUS:  rd_data_d = status;
            A_CYCLES:  rd_data_d = 64'(cycles_q);
            default:   rd_data_d = '0;
        endcase
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (addr == buf_addr_idx(i)) rd_data_d = baddr_q[i];
            if (addr == buf_size_idx(i)) rd_data_d = 64'(bsize_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            scratch_q <= '0;
            dsm_q     <= '0;
            control_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rej_q     <= 1'b0;
            cycles_q  <= '0;
            baddr_q   <= '0;
            bsize_q   <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            tx_q      <= '0;
        end else begin
            tx_q.mmioRdValid <= rx_mmio.mmioRdValid;
            tx_q.hdr.tid     <= rx_mmio.mmioRdValid ? rx_mmio.hdr.tid : '0;
            tx_q.data        <= rx_mmio.mmioRdValid ? rd_data_d : '0;
            start_q          <= 1'b0;
            abort_q          <= 1'b0;

            if (wr_en) begin
                case (addr)
                    A_SCRATCH: scratch_q <= rx_mmio.data;
                    A_DSM:     dsm_q     <= rx_mmio.data;
                    A_CTRL:    control_q <= rx_mmio.data[31:0];
                    default:   ;
                endcase
            end

            // Buffer descriptors are frozen while running; attempts are flagged.
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (wr_en && addr == buf_addr_idx(i)) begin
                    if (state_q == ST_RUN) rej_q <= 1'b1;
                    else                   baddr_q[i] <= rx_mmio.data;
                end
                if (wr_en && addr == buf_size_idx(i)) begin
                    if (state_q == ST_RUN) rej_q <= 1'b1;
                    else                   bsize_q[i] <= rx_mmio.data[SIZE_W-1:0];
                end
            end

            if (state_q == ST_RUN && accel_error) err_q <= 1'b1;
            // Counts every cycle spent in RUN, including the completing one.
            if (state_q == ST_RUN && cycles_q != '1) cycles_q <= cycles_q + CYCLE_W'(1);

            case (state_q)
                ST_RUN: begin
                    if (abort_req) begin
                        state_q <= ST_IDLE;
                        abort_q <= 1'b1;
                    end else if (accel_done) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    if (abort_req) begin
                        state_q <= ST_IDLE;
                    end else if (start_req) begin
                        state_q  <= ST_RUN;
                        start_q  <= 1'b1;
                        cycles_q <= '0;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        rej_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign tx_mmio     = tx_q;
    assign hc_dsm_base = dsm_q[47:6];
    assign hc_control  = control_q;
    assign hc_start    = start_q;
    assign hc_abort    = abort_q;
    assign hc_busy     = (state_q == ST_RUN);

    for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_buf
        assign buf_addr[42*i +: 42]         = baddr_q[i][47:6];
        assign buf_size[SIZE_W*i +: SIZE_W] = bsize_q[i];
    end

endmodule

// File: doc/hc_csr_bank.md
Name: hc_csr_bank

Overview:
- Parametrised MMIO CSR bank for HardCloud AFUs; next generation of the per-sample CSR block.
- Decodes CCI-P MMIO reads and writes, and serves the DFH, AFU ID, DSM base, control, and NUM_BUFFERS address/size pairs.
- Adds full register readback, a start/abort run-state machine, a sticky status word, a run-cycle counter and buffer-write protection while running.
- Sits between the CCI-P c0 Rx / c2 Tx MMIO channels and the accelerator datapath.

Parameters:
- NUM_BUFFERS, 2, number of buffer descriptor pairs (1..16).
- AFU_ID, 128'hC000C966_0D82_4272_9AEF_FE5F84570612, value returned at AFU_ID_L/H.
- SIZE_W, 32, width of each buffer size field (1..64).
- CYCLE_W, 48, width of the run-cycle counter (1..64); zero-extended on readback.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- rx_mmio  in  t_if_ccip_c0_Rx  MMIO request channel (mmioRdValid, mmioWrValid, hdr, data).
- tx_mmio  out  t_if_ccip_c2_Tx  MMIO read response (mmioRdValid, hdr.tid, data).
- hc_dsm_base  out  42  DSM cache-line address (written byte address >> 6).
- hc_control  out  32  last CONTROL write, bits [31:0].
- hc_start  out  1  one-cycle pulse on an accepted start.
- hc_abort  out  1  one-cycle pulse on an accepted abort.
- hc_busy  out  1  high while state == RUN.
- buf_addr  out  NUM_BUFFERS*42  packed cache-line addresses; entry i at [42*i +: 42].
- buf_size  out  NUM_BUFFERS*SIZE_W  packed sizes; entry i at [SIZE_W*i +: SIZE_W].
- accel_done  in  1  accelerator completion pulse.
- accel_error  in  1  accelerator error pulse.

Behaviour:
- Reset: reset_n is synchronous and active-low, with one clock. While reset_n == 0, all outputs and registers are 0 and the state is IDLE.
- Register map is in byte offsets. MMIO hdr.address is the 32-bit word index, so the decode compares against the offset >> 2. All registers are 64 bits wide.
  - 0x000 DFH (RO): bits[63:60]=1, bit[40]=1, all other bits 0.
  - 0x008 AFU_ID_L (RO); 0x010 AFU_ID_H (RO).
  - 0x018, 0x020 reserved (RO, return 0).
  - 0x028 SCRATCH (RW).
  - 0x030 DSM_BASE (RW): stores the full byte address; readback returns the stored value.
  - 0x038 CONTROL (RW).
  - 0x040 STATUS (RO).
  - 0x048 CYCLES (RO).
  - 0x100+16*i BUF_ADDR[i] (RW, byte address; buf_addr[i] = value >> 6).
  - 0x108+16*i BUF_SIZE[i] (RW, low SIZE_W bits stored, upper bits read 0).
- Reads:
  - Every mmioRdValid produces exactly one response on the next cycle: tx_mmio.mmioRdValid=1, hdr.tid echoed, data as mapped.
  - Unmapped or out-of-range addresses return 0.
  - Back-to-back reads are supported, one response per cycle.
- Writes:
  - Accepted only when mmioWrValid=1 and hdr.length == 2'b01 (8 bytes). Other lengths are dropped with no side effects.
  - Written registers update on the following clock edge.
  - Writes to RO or unmapped addresses are ignored.
- CONTROL write:
  - Always stores data[31:0] into hc_control.
  - bit0=1: start request. bit1=1: abort request. If both bits are set, abort wins.
- State machine IDLE/RUN/DONE:
  - IDLE or DONE + start → RUN. On this transition: hc_start pulses, CYCLES clears to 0, and the done, error and wr_reject bits clear.
  - RUN + accel_done → DONE; done bit set.
  - RUN + abort → IDLE; hc_abort pulses; done is not set.
  - Abort in IDLE or DONE → IDLE, no pulse.
  - Start in RUN is ignored (no pulse).
  - Same-cycle conflicts:
    - Abort write and accel_done in RUN → abort wins.
    - Start write and accel_done in DONE → start wins.
    - accel_done in IDLE or DONE is ignored.
- STATUS bits:
  - bit0 busy.
  - bit1 done (sticky).
  - bit2 error (sticky; set by accel_error only in RUN).
  - bit3 wr_reject (sticky).
  - bits[5:4] state encoding: IDLE=0, RUN=1, DONE=2.
  - All other bits are 0.
- CYCLES: increments by 1 on each cycle in RUN, saturates at all-ones, and holds in DONE and IDLE.
- Buffer protection: BUF_ADDR and BUF_SIZE writes while in RUN are dropped and set wr_reject. DSM_BASE and SCRATCH remain writable in every state.
- Simultaneous read and write in the same cycle: the read returns the pre-write value.

Test Plan:
- Reset, then read 0x000, 0x008 and 0x010 with tids 5, 6 and 7 → responses one cycle after each request, with tids 5/6/7 and data 0x1000010000000000, 0xC000C9660D824272 and 0x9AEFFE5F84570612.
- Write 0x1000 to DSM_BASE and 0xABCD_0040 to BUF_ADDR[1] (0x110) → hc_dsm_base=0x40, buf_addr entry 1 = 0x2AF3401; readback returns the written values. A 4-byte write to SCRATCH leaves it at 0.
- Write CONTROL=1, hold 10 cycles, then pulse accel_done → hc_start is a single pulse, STATUS=0x22 after done, CYCLES=11 and stays frozen.
- In RUN, write BUF_SIZE[0]=0x80 → buf_size unchanged and STATUS bit3=1. A new start clears bit3.
- In RUN, write CONTROL=3 in the same cycle as accel_done → hc_abort pulse, state IDLE, STATUS=0x00.
- Deassert reset_n mid-RUN → next cycle all outputs are 0, STATUS=0 and CYCLES=0; a read of address 0x3FF returns 0.
